// File: rtl/vga_line_scheduler_pkg.sv
// Shared VGA timing constants and the line scheduler state encoding.
package tinygpu_vga_pkg;

  localparam int H_TOTAL  = 800;
  localparam int H_ACTIVE = 640;
  localparam int V_TOTAL  = 525;
  localparam int V_ACTIVE = 480;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_BUSY = 2'd2,
    ST_WAIT = 2'd3
  } sched_state_e;

endpackage

// File: rtl/vga_line_scheduler.sv
// Per-scanline render scheduler: one render job per visible line, ping-pong buffer select, underrun detection.
// Build option VGA_SCHED_STATS_EN: live saturating underrun counter, and dropped requests also flag underrun.
module vga_line_scheduler
  import tinygpu_vga_pkg::*;
#(
  parameter int H_TOTAL  = tinygpu_vga_pkg::H_TOTAL,
  parameter int V_TOTAL  = tinygpu_vga_pkg::V_TOTAL,
  parameter int V_ACTIVE = tinygpu_vga_pkg::V_ACTIVE,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [9:0]       x,
  input  logic [9:0]       y,
  input  logic             enable,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [9:0]       req_line,
  input  logic             done,
  output logic             rend_buf,
  output logic             disp_buf,
  output logic             frame_start,
  output logic             underrun,
  output logic [CNT_W-1:0] underrun_cnt
);

  localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] Y_ACTIVE = 10'(V_ACTIVE);

  sched_state_e state_q, state_d;
  logic [9:0]   req_line_q, req_line_d;
  logic [9:0]   pend_line_q, pend_line_d;
  logic         rend_buf_q, rend_buf_d;
  logic         frame_start_q, frame_start_d;
  logic         underrun_q, underrun_d;

  logic         line_evt;
  logic [9:0]   nl;
  logic [9:0]   r;

  always_comb begin
    line_evt = (x == X_LAST);
    nl       = (y == Y_LAST) ? 10'd0 : y + 10'd1;
    r        = (nl == Y_LAST) ? 10'd0 : nl + 10'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      req_line_q    <= '0;
      pend_line_q   <= '0;
      rend_buf_q    <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_line_q    <= req_line_d;
      pend_line_q   <= pend_line_d;
      rend_buf_q    <= rend_buf_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  // Handshake transitions land first; the line event then sees the updated state.
  always_comb begin
    state_d       = state_q;
    req_line_d    = req_line_q;
    pend_line_d   = pend_line_q;
    rend_buf_d    = rend_buf_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;

    case (state_q)
      ST_REQ:  if (req_ready) state_d = ST_BUSY;
      ST_BUSY: if (done)      state_d = ST_WAIT;
      default: ;
    endcase

    if (line_evt) begin
      frame_start_d = (nl == 10'd0);
      if (nl < Y_ACTIVE) begin
        if ((state_d == ST_WAIT) && (pend_line_q == nl)) begin
          rend_buf_d = ~rend_buf_q;
          state_d    = ST_IDLE;
        end else begin
          underrun_d = 1'b1;
        end
      end
      // A job still in flight keeps the renderer; the new line is dropped and will miss its swap.
      if ((r < Y_ACTIVE) && enable) begin
        if ((state_d == ST_IDLE) || (state_d == ST_WAIT)) begin
          req_line_d  = r;
          pend_line_d = r;
          state_d     = ST_REQ;
        end
`ifdef VGA_SCHED_STATS_EN
        else begin
          underrun_d = 1'b1;
        end
`endif
      end
    end
  end

  always_comb begin
    req_valid   = (state_q == ST_REQ);
    req_line    = req_line_q;
    rend_buf    = rend_buf_q;
    disp_buf    = ~rend_buf_q;
    frame_start = frame_start_q;
    underrun    = underrun_q;
  end

`ifdef VGA_SCHED_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (underrun_d && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign underrun_cnt = cnt_q;
`else
  assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_line_scheduler.sv
// Testbench for vga_line_scheduler with shrunken timing: directed vector table, scenario sequences, random run.
`timescale 1ns/1ps
module tb_vga_line_scheduler;

  localparam int H  = 32;
  localparam int V  = 10;
  localparam int VA = 6;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [9:0]    x = '0;
  logic [9:0]    y = '0;
  logic          enable = 1'b0;
  logic          req_ready = 1'b0;
  logic          done = 1'b0;
  logic          req_valid;
  logic [9:0]    req_line;
  logic          rend_buf, disp_buf, frame_start, underrun;
  logic [CW-1:0] underrun_cnt;

  always #20 clk = ~clk;

  vga_line_scheduler #(.H_TOTAL(H), .V_TOTAL(V), .V_ACTIVE(VA), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .enable(enable),
    .req_valid(req_valid), .req_ready(req_ready), .req_line(req_line), .done(done),
    .rend_buf(rend_buf), .disp_buf(disp_buf), .frame_start(frame_start),
    .underrun(underrun), .underrun_cnt(underrun_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the job lifecycle (requested / rendering / rendered) per line.
  bit m_pend, m_job, m_rdy, m_rb, m_fs, m_ur;
  int m_req_line, m_job_line, m_rdy_line, m_cnt;

  task automatic model_reset();
    m_pend = 0; m_job = 0; m_rdy = 0; m_rb = 0; m_fs = 0; m_ur = 0;
    m_req_line = 0; m_job_line = 0; m_rdy_line = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    int nl, r;
    if (m_pend && req_ready) begin
      m_pend = 0; m_job = 1; m_job_line = m_req_line;
    end else if (m_job && done) begin
      m_job = 0; m_rdy = 1; m_rdy_line = m_job_line;
    end
    m_fs = 0; m_ur = 0;
    if (int'(x) == H - 1) begin
      nl = (int'(y) == V - 1) ? 0 : int'(y) + 1;
      m_fs = (nl == 0);
      if (nl < VA) begin
        if (m_rdy && m_rdy_line == nl) begin
          m_rb = !m_rb; m_rdy = 0;
        end else m_ur = 1;
      end
      r = (nl == V - 1) ? 0 : nl + 1;
      if (r < VA && enable) begin
        if (!m_pend && !m_job) begin
          m_rdy = 0; m_pend = 1; m_req_line = r;
        end
`ifdef VGA_SCHED_STATS_EN
        else m_ur = 1;
`endif
      end
`ifdef VGA_SCHED_STATS_EN
      if (m_ur && m_cnt < (1 << CW) - 1) m_cnt++;
`endif
    end
  endtask

  task automatic compare_all();
    check("req_valid", req_valid, m_pend);
    check("req_line", req_line, m_req_line);
    check("rend_buf", rend_buf, m_rb);
    check("disp_buf", disp_buf, !m_rb);
    check("frame_start", frame_start, m_fs);
    check("underrun", underrun, m_ur);
    check("underrun_cnt", underrun_cnt, m_cnt);
  endtask

  // Bench renderer and timing generator
  bit auto_tmg = 0, auto_ren = 0;
  bit ren_busy = 0;
  int ren_cnt = 0, bp_left = 0, done_lat = 10, slow_line = -1, slow_lat = 40;

  task automatic drive_renderer();
    done = 1'b0; req_ready = 1'b0;
    if (ren_busy) begin
      if (ren_cnt <= 1) begin done = 1'b1; ren_busy = 0; end
      else ren_cnt--;
    end else if (req_valid) begin
      if (bp_left > 0) bp_left--;
      else begin
        req_ready = 1'b1; ren_busy = 1;
        ren_cnt = (int'(req_line) == slow_line) ? slow_lat : done_lat;
      end
    end
  endtask

  int  mon_tog, mon_ur, mon_fs, mon_fsbad, mon_hold, mon_maxrun, vrun;
  bit  prev_disp, prev_valid;
  int  prev_line;
  int  reqs[$];

  task automatic clear_mon();
    mon_tog = 0; mon_ur = 0; mon_fs = 0; mon_fsbad = 0; mon_hold = 0; mon_maxrun = 0; vrun = 0;
    reqs.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_step();
    #1;
    if (auto_tmg) begin
      if (int'(x) == H - 1) begin
        x = '0; y = (int'(y) == V - 1) ? 10'd0 : y + 10'd1;
      end else x = x + 10'd1;
    end
    compare_all();
    if (disp_buf != prev_disp) mon_tog++;
    if (underrun) mon_ur++;
    if (frame_start) begin
      mon_fs++;
      if (!(x == 0 && y == 0)) mon_fsbad++;
    end
    if (req_valid && !prev_valid) reqs.push_back(int'(req_line));
    if (req_valid && prev_valid && int'(req_line) != prev_line) mon_hold++;
    if (req_valid) begin vrun++; if (vrun > mon_maxrun) mon_maxrun = vrun; end else vrun = 0;
    prev_disp = disp_buf; prev_valid = req_valid; prev_line = int'(req_line);
    if (auto_ren) drive_renderer();
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    #5 rst_n = 1'b0;
    model_reset();
    ren_busy = 0; done = 1'b0; req_ready = 1'b0; x = '0; y = '0; bp_left = 0;
    #1 compare_all();
    @(posedge clk); #1;
    compare_all();
    prev_disp = disp_buf; prev_valid = req_valid; prev_line = int'(req_line);
    rst_n = 1'b1;
  endtask

  typedef struct packed {
    logic [9:0] x, y;
    logic       en, rdy, dn;
    logic       e_valid;
    logic [9:0] e_line;
    logic       e_rb, e_ur, e_fs;
  } vec_t;

  vec_t tbl[17];
  int nom_exp[6]  = '{2, 3, 4, 5, 0, 1};
  int slow_exp[5] = '{2, 4, 5, 0, 1};

  initial begin
    #4_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, exp_first, yy, nl2, r2, budget;

    //            x      y     en rdy dn  val  line  rb ur fs
    tbl[0]  = '{10'd0,  10'd0, 1, 0, 0, 1'b0, 10'd0, 0, 0, 0};
    tbl[1]  = '{10'd31, 10'd8, 1, 0, 0, 1'b1, 10'd0, 0, 0, 0};
    tbl[2]  = '{10'd0,  10'd9, 1, 0, 0, 1'b1, 10'd0, 0, 0, 0};
    tbl[3]  = '{10'd1,  10'd9, 1, 1, 0, 1'b0, 10'd0, 0, 0, 0};
    tbl[4]  = '{10'd2,  10'd9, 1, 0, 1, 1'b0, 10'd0, 0, 0, 0};
    tbl[5]  = '{10'd31, 10'd9, 1, 0, 0, 1'b1, 10'd1, 1, 0, 1};
    tbl[6]  = '{10'd0,  10'd0, 1, 1, 0, 1'b0, 10'd1, 1, 0, 0};
    tbl[7]  = '{10'd31, 10'd0, 1, 0, 0, 1'b0, 10'd1, 1, 1, 0};
    tbl[8]  = '{10'd0,  10'd1, 1, 0, 1, 1'b0, 10'd1, 1, 0, 0};
    tbl[9]  = '{10'd31, 10'd1, 1, 0, 0, 1'b1, 10'd3, 1, 1, 0};
    tbl[10] = '{10'd31, 10'd2, 1, 0, 1, 1'b1, 10'd3, 1, 1, 0};
    tbl[11] = '{10'd31, 10'd3, 0, 1, 0, 1'b0, 10'd3, 1, 1, 0};
    tbl[12] = '{10'd5,  10'd4, 1, 0, 1, 1'b0, 10'd3, 1, 0, 0};
    tbl[13] = '{10'd31, 10'd2, 1, 0, 0, 1'b1, 10'd4, 0, 0, 0};
    tbl[14] = '{10'd31, 10'd5, 1, 0, 0, 1'b1, 10'd4, 0, 0, 0};
    tbl[15] = '{10'd0,  10'd3, 1, 1, 0, 1'b0, 10'd4, 0, 0, 0};
    tbl[16] = '{10'd31, 10'd3, 1, 0, 1, 1'b1, 10'd5, 1, 0, 0};

    clear_mon();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      x = tbl[i].x; y = tbl[i].y; enable = tbl[i].en; req_ready = tbl[i].rdy; done = tbl[i].dn;
      tick();
      check($sformatf("vec%0d_valid", i), req_valid, tbl[i].e_valid);
      check($sformatf("vec%0d_line", i), req_line, tbl[i].e_line);
      check($sformatf("vec%0d_rb", i), rend_buf, tbl[i].e_rb);
      check($sformatf("vec%0d_ur", i), underrun, tbl[i].e_ur);
      check($sformatf("vec%0d_fs", i), frame_start, tbl[i].e_fs);
    end

    // Nominal renderer
    auto_tmg = 1; auto_ren = 1; enable = 1'b1; done = 1'b0; req_ready = 1'b0;
    do_reset(); done_lat = 10;
    run_cycles(H * V);
    clear_mon(); run_cycles(H * V);
    check("nom_toggles", mon_tog, VA);
    check("nom_underruns", mon_ur, 0);
    check("nom_frame_starts", mon_fs, 1);
    check("nom_fs_misaligned", mon_fsbad, 0);
    check("nom_req_count", reqs.size(), 6);
    for (int i = 0; i < 6; i++) if (i < reqs.size()) check("nom_req_order", reqs[i], nom_exp[i]);

    // Slow renderer on line 2
    do_reset(); slow_line = 2; slow_lat = 40;
    run_cycles(H * V);
    c0 = int'(underrun_cnt);
    clear_mon(); run_cycles(H * V);
    check("slow_underruns", mon_ur, 2);
    check("slow_toggles", mon_tog, 4);
    check("slow_req_count", reqs.size(), 5);
    for (int i = 0; i < 5; i++) if (i < reqs.size()) check("slow_req_order", reqs[i], slow_exp[i]);
`ifdef VGA_SCHED_STATS_EN
    check("slow_cnt_delta", int'(underrun_cnt) - c0, 2);
`else
    check("slow_cnt_delta", int'(underrun_cnt) - c0, 0);
`endif
    slow_line = -1;

    // Backpressure on the first request of a frame
    do_reset(); done_lat = 5;
    run_cycles(H * V);
    bp_left = 20;
    clear_mon(); run_cycles(H * V);
    check("bp_underruns", mon_ur, 0);
    check("bp_toggles", mon_tog, VA);
    check("bp_line_hold", mon_hold, 0);
    check("bp_valid_run", mon_maxrun, 21);

    // enable dropped at line 2, then restored
    do_reset(); done_lat = 10;
    run_cycles(H * V + 2 * H);
    enable = 1'b0;
    clear_mon(); run_cycles(H * V);
    check("dis_toggles", mon_tog, 1);
    check("dis_underruns", mon_ur, 5);
    check("dis_reqs", reqs.size(), 0);
    clear_mon(); run_cycles(H * V);
    check("dis_full_underruns", mon_ur, VA);
    check("dis_full_toggles", mon_tog, 0);
    enable = 1'b1;
    clear_mon(); run_cycles(H * V);
    check("reen_req_count", reqs.size(), 6);
    if (reqs.size() > 0) check("reen_first_req", reqs[0], 4);

    // Reset while a job is in BUSY
    do_reset(); done_lat = 20;
    run_cycles(H * V);
    budget = 0;
    while (!(ren_busy && !req_valid && ren_cnt > 5) && budget < 2 * H * V) begin
      tick(); budget++;
    end
    check("busy_reached", int'(budget < 2 * H * V), 1);
    #5 rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_req_valid", req_valid, 0);
    check("rst_req_line", req_line, 0);
    check("rst_rend_buf", rend_buf, 0);
    check("rst_disp_buf", disp_buf, 1);
    check("rst_frame_start", frame_start, 0);
    check("rst_underrun", underrun, 0);
    check("rst_underrun_cnt", underrun_cnt, 0);
    tick();
    rst_n = 1'b1;
    exp_first = -1; yy = int'(y);
    for (int k = 0; k < V; k++) begin
      nl2 = (yy == V - 1) ? 0 : yy + 1;
      r2  = (nl2 == V - 1) ? 0 : nl2 + 1;
      if (exp_first < 0 && r2 < VA) exp_first = r2;
      yy = nl2;
    end
    clear_mon(); run_cycles(H * V);
    check("post_rst_has_req", int'(reqs.size() > 0), 1);
    if (reqs.size() > 0) check("post_rst_first_req", reqs[0], exp_first);

    // Randomized renderer latency, backpressure and enable
    do_reset();
    for (int i = 0; i < 4 * H * V; i++) begin
      tick();
      if (x == 0) begin
        done_lat = $urandom_range(1, 45);
        if ($urandom % 4 == 0) bp_left = $urandom_range(0, 12);
        enable = (($urandom % 8) != 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_line_scheduler.md
Name: vga_line_scheduler

Overview:
- Per-scanline render scheduler for the 640x480@60 display path.
- Watches the free-running x/y counters from the VGA timing generator and issues one render job per visible line to the line renderer over a valid/ready request with a done pulse.
- Owns the ping-pong line-buffer select: the renderer fills one buffer while the scan-out reads the other, and buffers swap at end of line.
- Detects and counts lines the renderer missed (underrun).

Parameters:
- H_TOTAL, 800, pixel clocks per line
- V_TOTAL, 525, lines per frame
- V_ACTIVE, 480, visible lines (must be < V_TOTAL-1)
- CNT_W, 8, underrun counter width

Ports:
- clk  in  1  pixel clock, 25 MHz
- rst_n  in  1  asynchronous active-low reset
- x  in  10  current pixel column from timing generator
- y  in  10  current line from timing generator
- enable  in  1  allow new render requests
- req_valid  out  1  render request pending
- req_ready  in  1  renderer accepts request
- req_line  out  10  line index to render
- done  in  1  one-cycle pulse: current job finished
- rend_buf  out  1  buffer the renderer writes
- disp_buf  out  1  buffer scan-out reads; always ~rend_buf
- frame_start  out  1  one-cycle pulse, line 0 about to display
- underrun  out  1  one-cycle pulse, expected line not ready
- underrun_cnt  out  CNT_W  saturating underrun count

Behaviour:
- Reset (async, rst_n=0): state IDLE, req_valid=0, req_line=0, rend_buf=0 (disp_buf=1), frame_start=0, underrun=0, underrun_cnt=0, pend_line=0. Reset mid-job abandons the job. A done pulse arriving after reset is ignored.
- Line event E: a cycle with x==H_TOTAL-1.
  - nl = (y==V_TOTAL-1) ? 0 : y+1, the line displayed from the next cycle.
- FSM states:
  - IDLE
  - REQ: req_valid=1
  - BUSY: waiting for done
  - WAIT: pend_line rendered, awaiting swap
- Transitions outside E:
  - REQ -> BUSY on req_ready.
  - BUSY -> WAIT on done.
  - done in any other state is ignored.
- Request payload: req_line and req_valid are registered and held stable while req_valid=1. They change only on acceptance.
- Evaluation order at E: done/req_ready transitions are applied first. Then:
  - (a) Swap check, only if nl < V_ACTIVE:
    - If state==WAIT and pend_line==nl: toggle rend_buf/disp_buf, state -> IDLE.
    - Otherwise: underrun=1 for one cycle, underrun_cnt+1 (saturating at all-ones), buffers unchanged (scan-out repeats the old line).
  - (b) Request due: r = (nl==V_TOTAL-1) ? 0 : nl+1, due when r < V_ACTIVE and enable=1.
    - If state (after a) is IDLE or WAIT: stale WAIT data is discarded; req_line<=r, pend_line<=r, state -> REQ.
    - If state is REQ or BUSY: request r is dropped; the outstanding job finishes into rend_buf and later fails the tag check.
- frame_start=1 for the cycle after E when nl==0, aligned with the first pixel of line 0.
- Line 0 is requested at E of line V_TOTAL-2 and rendered during the last blanking line.
- Outputs are registered; all pulses are exactly one cycle wide.
- enable=0 blocks new requests only. Outstanding jobs and swaps proceed normally.
- Latency: E -> req_valid high is 1 cycle. done -> WAIT is 1 cycle.

Optional Feature:
- VGA_SCHED_STATS_EN defined: underrun_cnt is live (saturating, cleared only by reset), and a dropped request also asserts underrun.
- Not defined: underrun_cnt tied to 0 with no counter flops; underrun pulses only on the swap-check failure.

Decomposition:
- Shared package tinygpu_vga_pkg holds:
  - timing constants (H_TOTAL, V_TOTAL, V_ACTIVE, H_ACTIVE)
  - the 2-bit scheduler state encoding
- No sub-module; the block is a flat single FSM plus buffer-select flop and counter.

Test Plan:
- Nominal: renderer takes req_ready immediately and gives done 300 cycles later. Check req_line sequence 0 (issued at y=523), then 1..479; disp_buf toggles 480 times per frame; underrun never asserts; frame_start once, at x=0 y=0.
- Slow renderer: done at 900 cycles for line 5. At E with nl=5: underrun=1, buffers hold, request 6 dropped; next E sees pend_line=5≠6, second underrun; request 7 issued; underrun_cnt=2.
- Backpressure: req_ready low for 50 cycles. req_line stays constant while valid, job proceeds after acceptance, swap succeeds if done precedes next E.
- Simultaneous: done and E in same cycle for matching line. Swap occurs, no underrun, next request issued the following cycle.
- enable deasserted at y=100: no requests after the in-flight job; underrun pulses each visible line; re-enable resumes at the next E.
- rst_n pulsed low mid-BUSY: all outputs return to reset values immediately; a late done is ignored; first request after reset is at the next due E.
